// File: rtl/store_write_buffer_pkg.sv
// Shared encodings for the store write buffer: access sizes, byte-enable
// constants, drain FSM states and the store alignment rule.
package store_write_buffer_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } drain_state_e;

  // Natural alignment: half on even bytes, word on word boundaries, 11 never legal.
  function automatic logic store_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_write_buffer_lane_aligner.sv
// Combinational store lane aligner: replicates right-justified store data
// across the byte lanes and derives little-endian byte enables.
module store_lane_aligner
  import store_write_buffer_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned
);

  // Lane replication and byte-enable generation per access size.
  always_comb begin
    wdata      = 32'h0000_0000;
    be         = BE_NONE;
    misaligned = store_misaligned(size, addr_lo);
    case (size)
      SIZE_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      SIZE_HALF: begin
        wdata = {2{data[15:0]}};
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SIZE_WORD: begin
        wdata = data;
        be    = BE_ALL;
      end
      default: begin
        wdata = 32'h0000_0000;
        be    = BE_NONE;
      end
    endcase
  end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: aligns sb/sh/sw stores into byte lanes, queues them in a
// small FIFO and drains them to data memory over a req/ack handshake.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [1:0]                 st_size,
  input  logic [AW-1:0]              st_addr,
  input  logic [31:0]                st_data,
  output logic                       st_misaligned,
  output logic                       mem_req,
  output logic [AW-1:0]              mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_be,
  input  logic                       mem_ack,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   align_wdata_s;
  logic [3:0]    align_be_s;
  logic          align_mis_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] count_next_s;
  drain_state_e  state_next_s;

  logic [AW-3:0] addr_mem_r  [DEPTH];
  logic [31:0]   wdata_mem_r [DEPTH];
  logic [3:0]    be_mem_r    [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          ready_r;
  logic          misaligned_r;
  drain_state_e  state_r;

  store_lane_aligner u_aligner (
    .size       (st_size),
    .addr_lo    (st_addr[1:0]),
    .data       (st_data),
    .wdata      (align_wdata_s),
    .be         (align_be_s),
    .misaligned (align_mis_s)
  );

  // Handshake qualification and next occupancy; a rejected store is consumed but never queued.
  always_comb begin
    accept_s     = st_valid && ready_r;
    push_s       = accept_s && !align_mis_s;
    pop_s        = (state_r == ISSUE) && mem_ack;
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Drain FSM next state; ISSUE holds across back-to-back entries so mem_req never dips.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (count_r != CW'(0)) state_next_s = ISSUE;
        else                   state_next_s = IDLE;
      end
      ISSUE: begin
        if (pop_s && (count_next_s == CW'(0))) state_next_s = IDLE;
        else                                   state_next_s = ISSUE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Control registers: pointers, occupancy, ready, misalign pulse and FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      ready_r      <= 1'b1;
      misaligned_r <= 1'b0;
      state_r      <= IDLE;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r      <= count_next_s;
      ready_r      <= (count_next_s != CW'(DEPTH));
      misaligned_r <= accept_s && align_mis_s;
      state_r      <= state_next_s;
    end
  end

  // FIFO payload storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_r[wr_ptr_r]  <= st_addr[AW-1:2];
      wdata_mem_r[wr_ptr_r] <= align_wdata_s;
      be_mem_r[wr_ptr_r]    <= align_be_s;
    end
  end

  assign st_ready      = ready_r;
  assign st_misaligned = misaligned_r;
  assign mem_req       = (state_r == ISSUE);
  assign mem_addr      = {addr_mem_r[rd_ptr_r], 2'b00};
  assign mem_wdata     = wdata_mem_r[rd_ptr_r];
  assign mem_be        = be_mem_r[rd_ptr_r];
  assign count         = count_r;

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: table of single-store lane
// vectors plus hand-written sequences for backpressure, overlap and reset.
module tb_store_write_buffer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_misaligned;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [2:0]  count;

  int n_cmp;
  int n_bad;

  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [3:0]  wr_be_q   [$];
  logic        mon_en;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic        mis;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic [3:0]  ebe;
  } vec_t;

  vec_t vecs [9];

  store_write_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .st_size       (st_size),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .st_misaligned (st_misaligned),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_ack       (mem_ack),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write that completes on the coming rising edge.
  always @(negedge clk) begin
    if (mon_en && !reset && mem_req && mem_ack) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_be_q.push_back(mem_be);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_be_q.delete();
  endtask

  task automatic drive_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic wait_writes(input int n, input string nm);
    int budget;
    budget = 0;
    while (wr_addr_q.size() < n && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk(nm, wr_addr_q.size(), n);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    mon_en   = 1'b1;
    reset    = 1'b1;
    st_valid = 1'b0;
    st_size  = 2'b00;
    st_addr  = 32'h0;
    st_data  = 32'h0;
    mem_ack  = 1'b1;

    vecs[0] = '{2'b00, 32'h0000_1003, 32'h0000_00AB, 1'b0, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000};
    vecs[1] = '{2'b00, 32'h0000_1000, 32'h1234_5678, 1'b0, 32'h0000_1000, 32'h7878_7878, 4'b0001};
    vecs[2] = '{2'b01, 32'h0000_2002, 32'h0000_1234, 1'b0, 32'h0000_2000, 32'h1234_1234, 4'b1100};
    vecs[3] = '{2'b01, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b0011};
    vecs[4] = '{2'b01, 32'h0000_2001, 32'h0000_1234, 1'b1, 32'h0,         32'h0,         4'b0000};
    vecs[5] = '{2'b10, 32'h0000_3000, 32'hCAFE_F00D, 1'b0, 32'h0000_3000, 32'hCAFE_F00D, 4'b1111};
    vecs[6] = '{2'b10, 32'h0000_3002, 32'hCAFE_F00D, 1'b1, 32'h0,         32'h0,         4'b0000};
    vecs[7] = '{2'b11, 32'h0000_4000, 32'h0000_0001, 1'b1, 32'h0,         32'h0,         4'b0000};
    vecs[8] = '{2'b00, 32'h0000_5001, 32'h0000_005A, 1'b0, 32'h0000_5000, 32'h5A5A_5A5A, 4'b0010};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_count", count, 0);
    chk("reset_ready", st_ready, 1);
    chk("reset_req", mem_req, 0);
    chk("reset_mis", st_misaligned, 0);

    // Single stores on an empty buffer, mem_ack tied high.
    for (int i = 0; i < 9; i++) begin
      drive_store(vecs[i].size, vecs[i].addr, vecs[i].data);
      @(negedge clk);
      st_valid = 1'b0;
      chk($sformatf("v%0d_mis_pulse", i), st_misaligned, vecs[i].mis);
      chk($sformatf("v%0d_count", i), count, vecs[i].mis ? 0 : 1);
      @(negedge clk);
      chk($sformatf("v%0d_req", i), mem_req, !vecs[i].mis);
      if (!vecs[i].mis) begin
        chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].eaddr);
        chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].ewdata);
        chk($sformatf("v%0d_be", i), mem_be, vecs[i].ebe);
      end
      chk($sformatf("v%0d_mis_once", i), st_misaligned, 0);
      @(negedge clk);
      chk($sformatf("v%0d_drained", i), count, 0);
      chk($sformatf("v%0d_idle", i), mem_req, 0);
    end

    // Backpressure: five words with ack low, fifth held until space frees up.
    clear_mon();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_store(2'b10, 32'h100 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
      chk($sformatf("bp_ready%0d", i), st_ready, 1);
      @(negedge clk);
    end
    chk("bp_count_full", count, 4);
    chk("bp_ready_full", st_ready, 0);
    drive_store(2'b10, 32'h110, 32'h5555_5555);
    repeat (3) begin
      @(negedge clk);
      chk("bp_held_count", count, 4);
      chk("bp_held_ready", st_ready, 0);
      chk("bp_held_req", mem_req, 1);
    end
    chk("bp_head_addr", mem_addr, 32'h100);
    mem_ack = 1'b1;
    begin
      int budget;
      budget = 0;
      while (!st_ready && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      chk("bp_ready_returns", st_ready, 1);
    end
    @(negedge clk);
    st_valid = 1'b0;
    wait_writes(5, "bp_writes");
    for (int i = 0; i < 5; i++) begin
      if (i < wr_addr_q.size()) begin
        chk($sformatf("bp_order_addr%0d", i), wr_addr_q[i], 32'h100 + 32'(4 * i));
        chk($sformatf("bp_order_data%0d", i), wr_data_q[i], 32'h1111_1111 * 32'(i + 1));
        chk($sformatf("bp_order_be%0d", i), wr_be_q[i], 4'b1111);
      end
    end
    repeat (2) @(negedge clk);
    chk("bp_final_count", count, 0);

    // Push and pop in the same cycle at count=2; req stays high throughout.
    clear_mon();
    mem_ack = 1'b0;
    drive_store(2'b10, 32'h200, 32'hA0A0_0001);
    @(negedge clk);
    drive_store(2'b10, 32'h204, 32'hA0A0_0002);
    @(negedge clk);
    chk("pp_count2", count, 2);
    chk("pp_req", mem_req, 1);
    drive_store(2'b10, 32'h208, 32'hA0A0_0003);
    mem_ack = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
    chk("pp_count_same", count, 2);
    chk("pp_req_b2b", mem_req, 1);
    chk("pp_next_head", mem_addr, 32'h204);
    @(negedge clk);
    chk("pp_count1", count, 1);
    chk("pp_req_b2b2", mem_req, 1);
    @(negedge clk);
    chk("pp_count0", count, 0);
    chk("pp_req_low", mem_req, 0);
    chk("pp_nwrites", wr_addr_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_addr_q.size())
        chk($sformatf("pp_order%0d", i), wr_data_q[i], 32'hA0A0_0001 + 32'(i));
    end

    // Reset mid-handshake with three entries queued.
    clear_mon();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_store(2'b00, 32'h300 + 32'(i), 32'h0000_0077);
      @(negedge clk);
    end
    st_valid = 1'b0;
    chk("rst_pre_count", count, 3);
    chk("rst_pre_req", mem_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_req", mem_req, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", st_ready, 1);
    mem_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_no_req", mem_req, 0);
    end
    chk("rst_no_writes", wr_addr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
